c2f_req_ctrl: RTL and testbench

// - Core-to-fabric requester. Detects core loads/stores at Q103H whose address core-ID field is

---
 rtl/lotr_pkg.sv | 34 +++
 rtl/c2f_req_fifo.sv | 60 ++++++
 rtl/c2f_req_ctrl.sv | 134 +++++++++++++
 tb/tb_c2f_req_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lotr_pkg.sv
// Shared types for the core-to-fabric requester: ring opcodes, request record,
// per-thread tracking states and the position of the core-ID field in an address.
package lotr_pkg;

  localparam int C2F_THREADS = 4;
  localparam int MSB_CORE_ID = 31;
  localparam int LSB_CORE_ID = 24;

  typedef enum logic [1:0] {
    RD     = 2'd0,
    WR     = 2'd1,
    RD_RSP = 2'd2
  } t_opcode;

  typedef struct packed {
    t_opcode                opcode;
    logic [31:0]            address;
    logic [31:0]            data;
    logic [C2F_THREADS-1:0] thread;
  } t_c2f_req;

  typedef enum logic [1:0] {
    T_IDLE     = 2'd0,
    T_QUEUED   = 2'd1,
    T_WAIT_RSP = 2'd2
  } t_thr_state;

  localparam logic [C2F_THREADS-1:0] THR_ONE = 1;

  function automatic logic is_onehot(input logic [C2F_THREADS-1:0] v);
    return (v != '0) && ((v & (v - THR_ONE)) == '0);
  endfunction

endpackage

// File: rtl/c2f_req_fifo.sv
// Synchronous FIFO of generic element type; head is read straight from the storage
// flops and forced to zero while empty so downstream fields idle at 0.
module c2f_req_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     head,
  output logic valid,
  output logic full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  T              mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  assign valid   = (count != '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);
  assign head    = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= inc(wr_ptr);
      if (do_pop)  rd_ptr <= inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/c2f_req_ctrl.sv
// Core-to-fabric requester: turns remote core loads/stores into ring RD/WR requests
// and routes RD_RSP data back to the thread that is waiting for it.
module c2f_req_ctrl
  import lotr_pkg::*;
#(
  parameter int NUM_THREADS = C2F_THREADS
) (
  input  logic                   QClk,
  input  logic                   RstQnnnH,
  input  logic [7:0]             CoreIdStrap,
  input  logic [NUM_THREADS-1:0] ThreadQ103H,
  input  logic [31:0]            AddressQ103H,
  input  logic [3:0]             ByteEnQ103H,
  input  logic [31:0]            WrDataQ103H,
  input  logic                   RdEnQ103H,
  input  logic                   WrEnQ103H,
  output logic [NUM_THREADS-1:0] ThreadPendingQnnnH,
  output logic                   C2F_RdRspValidQ104H,
  output logic [NUM_THREADS-1:0] C2F_RdRspThreadQ104H,
  output logic [31:0]            C2F_RdRspDataQ104H,
  output logic                   C2F_ErrStickyQnnnH,
  output logic                   C2F_ReqValidQ500H,
  input  logic                   C2F_ReqReadyQ500H,
  output t_opcode                C2F_ReqOpcodeQ500H,
  output logic [31:0]            C2F_ReqAddressQ500H,
  output logic [31:0]            C2F_ReqDataQ500H,
  output logic [NUM_THREADS-1:0] C2F_ReqThreadQ500H,
  input  logic                   C2F_RspValidQ502H,
  input  t_opcode                C2F_RspOpcodeQ502H,
  input  logic [NUM_THREADS-1:0] C2F_RspThreadQ502H,
  input  logic [31:0]            C2F_RspDataQ502H
);

  t_thr_state             state [NUM_THREADS];
  logic [NUM_THREADS-1:0] pending;
  logic [NUM_THREADS-1:0] waiting;
  logic [7:0]             core_id;
  logic                   access;
  logic                   remote;
  logic                   req_err;
  logic                   push;
  logic                   pop;
  logic                   rsp_hit;
  logic                   rsp_err;
  logic                   head_valid;
  logic                   fifo_full;
  t_c2f_req               push_req;
  t_c2f_req               head;

  always_comb begin
    pending = '0;
    waiting = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      pending[t] = (state[t] != T_IDLE);
      waiting[t] = (state[t] == T_WAIT_RSP);
    end
  end

  // Q103H decode: a remote access targets neither core 0 nor this core.
  assign core_id = AddressQ103H[MSB_CORE_ID:LSB_CORE_ID];
  assign access  = RdEnQ103H | WrEnQ103H;
  assign remote  = access && (core_id != '0) && (core_id != CoreIdStrap);
  assign pop     = head_valid && C2F_ReqReadyQ500H;

  // Bad accesses are dropped outright; the ring only carries full-word writes.
  assign req_err = (access && ((RdEnQ103H && WrEnQ103H) || ((ThreadQ103H & pending) != '0)))
                || (remote && WrEnQ103H && (ByteEnQ103H != 4'b1111))
                || (remote && fifo_full && !pop);
  assign push    = remote && !req_err;

  always_comb begin
    push_req         = '0;
    push_req.opcode  = WrEnQ103H ? WR : RD;
    push_req.address = AddressQ103H;
    push_req.data    = WrEnQ103H ? WrDataQ103H : '0;
    push_req.thread  = ThreadQ103H;
  end

  assign rsp_hit = C2F_RspValidQ502H && (C2F_RspOpcodeQ502H == RD_RSP)
                && is_onehot(C2F_RspThreadQ502H) && ((C2F_RspThreadQ502H & waiting) != '0);
  assign rsp_err = C2F_RspValidQ502H && !rsp_hit;

  c2f_req_fifo #(
    .DEPTH (NUM_THREADS),
    .T     (t_c2f_req)
  ) u_fifo (
    .clk   (QClk),
    .rst   (RstQnnnH),
    .push  (push),
    .din   (push_req),
    .pop   (pop),
    .head  (head),
    .valid (head_valid),
    .full  (fifo_full)
  );

  assign C2F_ReqValidQ500H   = head_valid;
  assign C2F_ReqOpcodeQ500H  = head.opcode;
  assign C2F_ReqAddressQ500H = head.address;
  assign C2F_ReqDataQ500H    = head.data;
  assign C2F_ReqThreadQ500H  = head.thread;
  assign ThreadPendingQnnnH  = pending;

  // Writes are posted: they retire on the ring accept, reads wait for RD_RSP.
  always_ff @(posedge QClk) begin
    for (int t = 0; t < NUM_THREADS; t++) begin
      if (RstQnnnH) begin
        state[t] <= T_IDLE;
      end else if (push && ThreadQ103H[t]) begin
        state[t] <= T_QUEUED;
      end else if (pop && head.thread[t]) begin
        state[t] <= (head.opcode == RD) ? T_WAIT_RSP : T_IDLE;
      end else if (rsp_hit && C2F_RspThreadQ502H[t]) begin
        state[t] <= T_IDLE;
      end
    end
  end

  // Q104H response capture and sticky error.
  always_ff @(posedge QClk) begin
    if (RstQnnnH) begin
      C2F_RdRspValidQ104H  <= 1'b0;
      C2F_RdRspThreadQ104H <= '0;
      C2F_RdRspDataQ104H   <= '0;
      C2F_ErrStickyQnnnH   <= 1'b0;
    end else begin
      C2F_RdRspValidQ104H  <= rsp_hit;
      C2F_RdRspThreadQ104H <= rsp_hit ? C2F_RspThreadQ502H : '0;
      C2F_RdRspDataQ104H   <= rsp_hit ? C2F_RspDataQ502H : '0;
      C2F_ErrStickyQnnnH   <= C2F_ErrStickyQnnnH | req_err | rsp_err;
    end
  end

endmodule

// File: tb/tb_c2f_req_ctrl.sv
// Directed bench for c2f_req_ctrl: a table of per-cycle stimulus/expectation rows
// followed by hand-written ready-stall and reset-during-read sequences.
module tb_c2f_req_ctrl;
  import lotr_pkg::*;

  logic        QClk = 1'b0;
  logic        RstQnnnH;
  logic [7:0]  CoreIdStrap;
  logic [3:0]  ThreadQ103H;
  logic [31:0] AddressQ103H;
  logic [3:0]  ByteEnQ103H;
  logic [31:0] WrDataQ103H;
  logic        RdEnQ103H;
  logic        WrEnQ103H;
  logic [3:0]  ThreadPendingQnnnH;
  logic        C2F_RdRspValidQ104H;
  logic [3:0]  C2F_RdRspThreadQ104H;
  logic [31:0] C2F_RdRspDataQ104H;
  logic        C2F_ErrStickyQnnnH;
  logic        C2F_ReqValidQ500H;
  logic        C2F_ReqReadyQ500H;
  t_opcode     C2F_ReqOpcodeQ500H;
  logic [31:0] C2F_ReqAddressQ500H;
  logic [31:0] C2F_ReqDataQ500H;
  logic [3:0]  C2F_ReqThreadQ500H;
  logic        C2F_RspValidQ502H;
  t_opcode     C2F_RspOpcodeQ502H;
  logic [3:0]  C2F_RspThreadQ502H;
  logic [31:0] C2F_RspDataQ502H;

  always #5 QClk = ~QClk;

  c2f_req_ctrl #(.NUM_THREADS(4)) dut (
    .QClk                 (QClk),
    .RstQnnnH             (RstQnnnH),
    .CoreIdStrap          (CoreIdStrap),
    .ThreadQ103H          (ThreadQ103H),
    .AddressQ103H         (AddressQ103H),
    .ByteEnQ103H          (ByteEnQ103H),
    .WrDataQ103H          (WrDataQ103H),
    .RdEnQ103H            (RdEnQ103H),
    .WrEnQ103H            (WrEnQ103H),
    .ThreadPendingQnnnH   (ThreadPendingQnnnH),
    .C2F_RdRspValidQ104H  (C2F_RdRspValidQ104H),
    .C2F_RdRspThreadQ104H (C2F_RdRspThreadQ104H),
    .C2F_RdRspDataQ104H   (C2F_RdRspDataQ104H),
    .C2F_ErrStickyQnnnH   (C2F_ErrStickyQnnnH),
    .C2F_ReqValidQ500H    (C2F_ReqValidQ500H),
    .C2F_ReqReadyQ500H    (C2F_ReqReadyQ500H),
    .C2F_ReqOpcodeQ500H   (C2F_ReqOpcodeQ500H),
    .C2F_ReqAddressQ500H  (C2F_ReqAddressQ500H),
    .C2F_ReqDataQ500H     (C2F_ReqDataQ500H),
    .C2F_ReqThreadQ500H   (C2F_ReqThreadQ500H),
    .C2F_RspValidQ502H    (C2F_RspValidQ502H),
    .C2F_RspOpcodeQ502H   (C2F_RspOpcodeQ502H),
    .C2F_RspThreadQ502H   (C2F_RspThreadQ502H),
    .C2F_RspDataQ502H     (C2F_RspDataQ502H)
  );

  typedef struct {
    logic        rst;
    logic        rd;
    logic        wr;
    logic [3:0]  thr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ready;
    logic        rspv;
    t_opcode     rspop;
    logic [3:0]  rspthr;
    logic [31:0] rspdata;
  } in_t;

  typedef struct {
    logic        rv;
    t_opcode     rop;
    logic [31:0] raddr;
    logic [31:0] rdata;
    logic [3:0]  rthr;
    logic [3:0]  pend;
    logic        ov;
    logic [3:0]  othr;
    logic [31:0] odata;
    logic        err;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic in_t idle(input logic ready);
    in_t v;
    v = '{rst: '0, rd: '0, wr: '0, thr: '0, addr: '0, be: '0, wdata: '0,
          ready: ready, rspv: '0, rspop: RD, rspthr: '0, rspdata: '0};
    return v;
  endfunction

  function automatic in_t ld(input logic [3:0] thr, input logic [31:0] addr, input logic ready);
    in_t v;
    v = idle(ready);
    v.rd = 1'b1; v.thr = thr; v.addr = addr; v.be = 4'hF;
    return v;
  endfunction

  function automatic in_t st(input logic [3:0] thr, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] be, input logic ready);
    in_t v;
    v = idle(ready);
    v.wr = 1'b1; v.thr = thr; v.addr = addr; v.wdata = data; v.be = be;
    return v;
  endfunction

  function automatic in_t rsp(input logic [3:0] thr, input logic [31:0] data, input t_opcode op);
    in_t v;
    v = idle(1'b1);
    v.rspv = 1'b1; v.rspop = op; v.rspthr = thr; v.rspdata = data;
    return v;
  endfunction

  function automatic in_t rstin();
    in_t v;
    v = idle(1'b0);
    v.rst = 1'b1;
    return v;
  endfunction

  function automatic exp_t exn(input logic [3:0] pend, input logic err);
    exp_t e;
    e = '{rv: '0, rop: RD, raddr: '0, rdata: '0, rthr: '0, pend: pend,
          ov: '0, othr: '0, odata: '0, err: err};
    return e;
  endfunction

  function automatic exp_t exq(input t_opcode op, input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] thr, input logic [3:0] pend, input logic err);
    exp_t e;
    e = exn(pend, err);
    e.rv = 1'b1; e.rop = op; e.raddr = addr; e.rdata = data; e.rthr = thr;
    return e;
  endfunction

  function automatic exp_t exr(input logic [3:0] thr, input logic [31:0] data,
                               input logic [3:0] pend, input logic err);
    exp_t e;
    e = exn(pend, err);
    e.ov = 1'b1; e.othr = thr; e.odata = data;
    return e;
  endfunction

  task automatic apply(input in_t v);
    RstQnnnH           = v.rst;
    RdEnQ103H          = v.rd;
    WrEnQ103H          = v.wr;
    ThreadQ103H        = v.thr;
    AddressQ103H       = v.addr;
    ByteEnQ103H        = v.be;
    WrDataQ103H        = v.wdata;
    C2F_ReqReadyQ500H  = v.ready;
    C2F_RspValidQ502H  = v.rspv;
    C2F_RspOpcodeQ502H = v.rspop;
    C2F_RspThreadQ502H = v.rspthr;
    C2F_RspDataQ502H   = v.rspdata;
  endtask

  task automatic tick();
    @(posedge QClk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    chk({tag, ".req_valid"},  32'(C2F_ReqValidQ500H),    32'(e.rv));
    chk({tag, ".req_opcode"}, 32'(C2F_ReqOpcodeQ500H),   32'(e.rop));
    chk({tag, ".req_addr"},   C2F_ReqAddressQ500H,       e.raddr);
    chk({tag, ".req_data"},   C2F_ReqDataQ500H,          e.rdata);
    chk({tag, ".req_thread"}, 32'(C2F_ReqThreadQ500H),   32'(e.rthr));
    chk({tag, ".pending"},    32'(ThreadPendingQnnnH),   32'(e.pend));
    chk({tag, ".rsp_valid"},  32'(C2F_RdRspValidQ104H),  32'(e.ov));
    chk({tag, ".rsp_thread"}, 32'(C2F_RdRspThreadQ104H), 32'(e.othr));
    chk({tag, ".rsp_data"},   C2F_RdRspDataQ104H,        e.odata);
    chk({tag, ".err"},        32'(C2F_ErrStickyQnnnH),   32'(e.err));
  endtask

  initial begin
    CoreIdStrap = 8'h02;
    apply(rstin());
    tick();
    tick();
    check_all("reset", exn(4'b0000, 1'b0));

    // Single remote load on T0 and its response.
    tbl.push_back('{ld(4'b0001, 32'h0340_0100, 1'b1), exq(RD, 32'h0340_0100, 32'h0, 4'b0001, 4'b0001, 1'b0)});
    tbl.push_back('{idle(1'b1),                        exn(4'b0001, 1'b0)});
    tbl.push_back('{rsp(4'b0001, 32'hDEAD_BEEF, RD_RSP), exr(4'b0001, 32'hDEAD_BEEF, 4'b0000, 1'b0)});
    tbl.push_back('{idle(1'b1),                        exn(4'b0000, 1'b0)});
    // Four threads back to back with Ready toggling, then out-of-order responses.
    tbl.push_back('{ld(4'b0001, 32'h0300_0010, 1'b0), exq(RD, 32'h0300_0010, 32'h0, 4'b0001, 4'b0001, 1'b0)});
    tbl.push_back('{ld(4'b0010, 32'h0300_0020, 1'b1), exq(RD, 32'h0300_0020, 32'h0, 4'b0010, 4'b0011, 1'b0)});
    tbl.push_back('{ld(4'b0100, 32'h0300_0030, 1'b0), exq(RD, 32'h0300_0020, 32'h0, 4'b0010, 4'b0111, 1'b0)});
    tbl.push_back('{ld(4'b1000, 32'h0300_0040, 1'b1), exq(RD, 32'h0300_0030, 32'h0, 4'b0100, 4'b1111, 1'b0)});
    tbl.push_back('{idle(1'b0),                        exq(RD, 32'h0300_0030, 32'h0, 4'b0100, 4'b1111, 1'b0)});
    tbl.push_back('{idle(1'b1),                        exq(RD, 32'h0300_0040, 32'h0, 4'b1000, 4'b1111, 1'b0)});
    tbl.push_back('{idle(1'b1),                        exn(4'b1111, 1'b0)});
    tbl.push_back('{rsp(4'b1000, 32'hA3A3_A3A3, RD_RSP), exr(4'b1000, 32'hA3A3_A3A3, 4'b0111, 1'b0)});
    tbl.push_back('{rsp(4'b0001, 32'hA0A0_A0A0, RD_RSP), exr(4'b0001, 32'hA0A0_A0A0, 4'b0110, 1'b0)});
    tbl.push_back('{rsp(4'b0100, 32'hA2A2_A2A2, RD_RSP), exr(4'b0100, 32'hA2A2_A2A2, 4'b0010, 1'b0)});
    tbl.push_back('{rsp(4'b0010, 32'hA1A1_A1A1, RD_RSP), exr(4'b0010, 32'hA1A1_A1A1, 4'b0000, 1'b0)});
    tbl.push_back('{idle(1'b1),                        exn(4'b0000, 1'b0)});
    // Local accesses (core field 0x00 and the strap 0x02) are ignored.
    tbl.push_back('{ld(4'b0001, 32'h0000_1000, 1'b1), exn(4'b0000, 1'b0)});
    tbl.push_back('{ld(4'b0010, 32'h0200_1000, 1'b1), exn(4'b0000, 1'b0)});
    tbl.push_back('{st(4'b0100, 32'h0200_0040, 32'h55, 4'hF, 1'b1), exn(4'b0000, 1'b0)});
    tbl.push_back('{idle(1'b1),                        exn(4'b0000, 1'b0)});
    // Error cases, each isolated by a reset.
    tbl.push_back('{rsp(4'b0100, 32'h1111_1111, RD_RSP), exn(4'b0000, 1'b1)});
    tbl.push_back('{rstin(),                           exn(4'b0000, 1'b0)});
    tbl.push_back('{st(4'b0010, 32'h0300_0100, 32'h1234_5678, 4'b0011, 1'b1), exn(4'b0000, 1'b1)});
    tbl.push_back('{idle(1'b1),                        exn(4'b0000, 1'b1)});
    tbl.push_back('{rstin(),                           exn(4'b0000, 1'b0)});
    tbl.push_back('{ld(4'b0001, 32'h0300_0010, 1'b0), exq(RD, 32'h0300_0010, 32'h0, 4'b0001, 4'b0001, 1'b0)});
    tbl.push_back('{ld(4'b0001, 32'h0300_0050, 1'b0), exq(RD, 32'h0300_0010, 32'h0, 4'b0001, 4'b0001, 1'b1)});
    tbl.push_back('{idle(1'b1),                        exn(4'b0001, 1'b1)});
    tbl.push_back('{rsp(4'b0001, 32'h0000_BEEF, RD_RSP), exr(4'b0001, 32'h0000_BEEF, 4'b0000, 1'b1)});
    tbl.push_back('{rstin(),                           exn(4'b0000, 1'b0)});
    tbl.push_back('{ld(4'b0100, 32'h0300_0070, 1'b1), exq(RD, 32'h0300_0070, 32'h0, 4'b0100, 4'b0100, 1'b0)});
    tbl.push_back('{idle(1'b1),                        exn(4'b0100, 1'b0)});
    tbl.push_back('{rsp(4'b0100, 32'h9999_9999, WR),  exn(4'b0100, 1'b1)});
    tbl.push_back('{rstin(),                           exn(4'b0000, 1'b0)});

    foreach (tbl[k]) begin
      apply(tbl[k].i);
      tick();
      check_all($sformatf("row%0d", k), tbl[k].e);
    end

    // Posted store held while Ready is low, retired on the accept cycle.
    apply(st(4'b0010, 32'h0340_0200, 32'h1234_5678, 4'hF, 1'b0));
    tick();
    check_all("st_push", exq(WR, 32'h0340_0200, 32'h1234_5678, 4'b0010, 4'b0010, 1'b0));
    for (int c = 0; c < 5; c++) begin
      apply(idle(1'b0));
      tick();
      check_all($sformatf("st_hold%0d", c), exq(WR, 32'h0340_0200, 32'h1234_5678, 4'b0010, 4'b0010, 1'b0));
    end
    apply(idle(1'b1));
    tick();
    check_all("st_accept", exn(4'b0000, 1'b0));
    apply(idle(1'b1));
    tick();
    check_all("st_posted", exn(4'b0000, 1'b0));

    // Reset while T0 waits for read data; the late response is an error only.
    apply(ld(4'b0001, 32'h0340_0100, 1'b1));
    tick();
    check_all("mr_push", exq(RD, 32'h0340_0100, 32'h0, 4'b0001, 4'b0001, 1'b0));
    apply(idle(1'b1));
    tick();
    check_all("mr_wait", exn(4'b0001, 1'b0));
    apply(rstin());
    tick();
    check_all("mr_reset", exn(4'b0000, 1'b0));
    apply(rsp(4'b0001, 32'hDEAD_BEEF, RD_RSP));
    tick();
    check_all("mr_late_rsp", exn(4'b0000, 1'b1));
    apply(idle(1'b1));
    tick();
    check_all("mr_sticky", exn(4'b0000, 1'b1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
